// File: rtl/regfile_param.sv
// regfile_param: parametrised 2R/1W register file with clear-on-reset sequencer; optional write-to-read bypass via REGFILE_BYPASS_EN
module regfile_param #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  output logic [WIDTH-1:0]  top_data,
  output logic              busy
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic [WIDTH-1:0]  rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0]  rs_rd, rt_rd;
  // read-port source: array value, or the incoming write data when bypass is built in
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    rs_rd = (write && rs_addr == rd_addr) ? data : regs_q[rs_addr];
    rt_rd = (write && rt_addr == rd_addr) ? data : regs_q[rt_addr];
`else
    rs_rd = regs_q[rs_addr];
    rt_rd = regs_q[rt_addr];
`endif
  end
  // next state: clear walk one entry per cycle, then normal read/write operation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    rs_d    = rs_rd;
    rt_d    = rt_rd;
    if (state_q == CLEAR) begin
      regs_d[idx_q] = '0;
      rs_d          = '0;
      rt_d          = '0;
      idx_d         = (idx_q == LAST) ? idx_q : idx_q + ADDR_W'(1);
      state_d       = (idx_q == LAST) ? RUN : CLEAR;
    end else if (write) begin
      regs_d[rd_addr] = data;
    end
  end
  // control and read flops; reset restarts the clear walk from entry 0
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
    end
  end
  // storage array; the reset edge itself leaves contents untouched
  always_ff @(posedge clock) begin
    if (!reset) regs_q <= regs_d;
  end
  assign rs_data  = rs_q;
  assign rt_data  = rt_q;
  assign busy     = (state_q == CLEAR);
  assign top_data = (state_q == CLEAR) ? '0 : regs_q[DEPTH-1];
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: table, directed and random checks of regfile_param against a behavioural model
module tb_regfile_param;
  localparam int W = 16;
  localparam int D = 8;
  localparam int A = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic         reset, write, busy;
  logic [A-1:0] rd_addr, rs_addr, rt_addr;
  logic [W-1:0] data, rs_data, rt_data, top_data;
  logic         reset2, write2, busy2;
  logic [3:0]   rd_addr2, rs_addr2, rt_addr2;
  logic [31:0]  data2, rs_data2, rt_data2, top_data2;
  regfile_param dut (
    .clock(clock), .reset(reset), .write(write), .rd_addr(rd_addr), .data(data),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .top_data(top_data), .busy(busy)
  );
  regfile_param #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) dut2 (
    .clock(clock), .reset(reset2), .write(write2), .rd_addr(rd_addr2), .data(data2),
    .rs_addr(rs_addr2), .rt_addr(rt_addr2), .rs_data(rs_data2), .rt_data(rt_data2),
    .top_data(top_data2), .busy(busy2)
  );
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] m_mem [D];
  int           m_clear_left = D;
  logic [W-1:0] m_rs, m_rt, m_top;
  logic         m_busy;
  typedef struct {
    bit           wr;
    logic [A-1:0] rd;
    logic [W-1:0] dat;
    logic [A-1:0] rs;
    logic [A-1:0] rt;
    logic [W-1:0] ers;
    logic [W-1:0] ert;
    logic [W-1:0] etop;
  } vec_t;
  vec_t tbl [6];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    if (reset) begin
      m_clear_left = D;
      m_rs = '0;
      m_rt = '0;
    end else if (m_clear_left > 0) begin
      m_mem[D - m_clear_left] = '0;
      m_clear_left--;
      m_rs = '0;
      m_rt = '0;
    end else begin
      m_rs = (BYP && write && rs_addr == rd_addr) ? data : m_mem[rs_addr];
      m_rt = (BYP && write && rt_addr == rd_addr) ? data : m_mem[rt_addr];
      if (write) m_mem[rd_addr] = data;
    end
    m_busy = (m_clear_left != 0);
    m_top  = m_busy ? '0 : m_mem[D-1];
  endtask
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("busy", busy, m_busy);
    check("rs_data", rs_data, m_rs);
    check("rt_data", rt_data, m_rt);
    check("top_data", top_data, m_top);
  endtask
  task automatic wait_idle(input bit which, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((which ? busy2 : busy) && n < 100);
  endtask
  initial begin
    int n;
    foreach (m_mem[i]) m_mem[i] = '0;
    tbl[0] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd3, BYP ? 16'hA5A5 : 16'h0000, BYP ? 16'hA5A5 : 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5, 16'h0000};
    tbl[2] = '{1'b1, 3'd7, 16'h1234, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h1234};
    tbl[3] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd0, 16'h1234, 16'h0000, 16'h1234};
    tbl[4] = '{1'b1, 3'd7, 16'hBEEF, 3'd7, 3'd3, BYP ? 16'hBEEF : 16'h1234, 16'hA5A5, 16'hBEEF};
    tbl[5] = '{1'b0, 3'd1, 16'h5555, 3'd7, 3'd7, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    reset = 1'b1; write = 1'b0; rd_addr = '0; rs_addr = '0; rt_addr = '0; data = '0;
    reset2 = 1'b1; write2 = 1'b0; rd_addr2 = '0; rs_addr2 = '0; rt_addr2 = '0; data2 = '0;
    tick();
    reset = 1'b0;
    wait_idle(1'b0, n);
    check("busy_cycles_after_reset", n, 8);
    for (int i = 0; i < D; i++) begin
      rs_addr = A'(i);
      rt_addr = A'(D - 1 - i);
      tick();
      check("cleared_rs", rs_data, 0);
      check("cleared_rt", rt_data, 0);
      check("cleared_top", top_data, 0);
    end
    for (int i = 0; i < 6; i++) begin
      write = tbl[i].wr; rd_addr = tbl[i].rd; data = tbl[i].dat;
      rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
      tick();
      check("tbl_rs", rs_data, tbl[i].ers);
      check("tbl_rt", rt_data, tbl[i].ert);
      check("tbl_top", top_data, tbl[i].etop);
    end
    write = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    write = 1'b1; rd_addr = 3'd2; data = 16'hFFFF;
    tick();
    write = 1'b1; rd_addr = 3'd0; data = 16'hFFFF;
    tick();
    write = 1'b0;
    wait_idle(1'b0, n);
    rs_addr = 3'd2; rt_addr = 3'd0;
    tick();
    check("clear_write_ignored_r2", rs_data, 0);
    check("clear_write_ignored_r0", rt_data, 0);
    write = 1'b1; rd_addr = 3'd6; data = 16'h0BAD;
    tick();
    write = 1'b0; rs_addr = 3'd6;
    tick();
    check("r6_written", rs_data, 16'h0BAD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("busy_mid_clear", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(1'b0, n);
    check("busy_cycles_after_rereset", n, 8);
    tick();
    check("r6_recleared", rs_data, 0);
    repeat (400) begin
      reset   = ($urandom_range(0, 49) == 0);
      write   = 1'($urandom);
      rd_addr = A'($urandom);
      rs_addr = ($urandom_range(0, 3) == 0) ? rd_addr : A'($urandom);
      rt_addr = ($urandom_range(0, 3) == 0) ? rd_addr : A'($urandom);
      data    = W'($urandom);
      tick();
    end
    reset = 1'b0; write = 1'b0;
    wait_idle(1'b0, n);
    reset2 = 1'b0;
    wait_idle(1'b1, n);
    check("busy2_cycles", n, 16);
    write2 = 1'b1; rd_addr2 = 4'd15; data2 = 32'hDEADBEEF;
    tick();
    write2 = 1'b0;
    check("top2_after_write", top_data2, 32'hDEADBEEF);
    rs_addr2 = 4'd15; rt_addr2 = 4'd0;
    tick();
    check("rs2_r15", rs_data2, 32'hDEADBEEF);
    check("rt2_r0", rt_data2, 0);
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    wait_idle(1'b1, n);
    check("busy2_cycles_rereset", n, 16);
    tick();
    check("rs2_r15_cleared", rs_data2, 0);
    check("top2_cleared", top_data2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
